led_strip_sequencer: RTL

- Frame-level controller for the single-pixel `led_driver` serializer.
- On `start`, walks a frame buffer of NUM_LEDS 24-bit colours, applies global brightness scaling, and hands each word to `led_driver` with a load/done handshake.
- After the last pixel, holds the line idle for the WS2812 latch/reset period, then signals frame completion.
- Sits between the pixel RAM (written by the SPI/MCU side) and `led_driver`.

---
 rtl/led_pkg.sv | 32 +++
 rtl/pixel_scale.sv | 18 +
 rtl/led_strip_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/led_pkg.sv
// led_pkg: shared types for the LED strip sequencer.
// Holds the FSM states, the colour word and the brightness helper.
package led_pkg;

  localparam int DEFAULT_RESET_CYCLES = 3000;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_DATA,
    LOAD,
    SEND,
    LATCH
  } seq_state_t;

  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } rgb_t;

  // c * (bright + 1) >> 8; bright = 255 passes c through unchanged
  function automatic logic [7:0] scale_ch(
    input logic [7:0] c,
    input logic [7:0] bright
  );
    logic [15:0] prod;
    prod = 16'(c) * (16'(bright) + 16'd1);
    return 8'(prod >> 8);
  endfunction

endpackage

// File: rtl/pixel_scale.sv
// pixel_scale: combinational brightness scaling of one colour word.
// Channels are scaled independently; their order is preserved.
module pixel_scale
  import led_pkg::*;
(
  input  rgb_t       pix_in,
  input  logic [7:0] bright,
  output rgb_t       pix_out
);

  // three independent multiply-shift channels
  always_comb begin
    pix_out.g = scale_ch(pix_in.g, bright);
    pix_out.r = scale_ch(pix_in.r, bright);
    pix_out.b = scale_ch(pix_in.b, bright);
  end

endmodule

// File: rtl/led_strip_sequencer.sv
// led_strip_sequencer: walks the pixel RAM, scales each colour and
// feeds led_driver, then holds the line idle for the strip latch.
module led_strip_sequencer
  import led_pkg::*;
#(
  parameter int NUM_LEDS     = 8,
  parameter int RESET_CYCLES = DEFAULT_RESET_CYCLES,
  parameter int DONE_TIMEOUT = 4096,
  localparam int ADDR_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        bright,
  output logic              pix_rd,
  output logic [ADDR_W-1:0] pix_addr,
  input  logic [23:0]       pix_data,
  output logic [23:0]       drv_rgb,
  output logic              drv_load,
  input  logic              drv_done,
  output logic              busy,
  output logic              frame_done,
  output logic              err
);

  localparam int LC_W = $clog2(RESET_CYCLES + 1);
  localparam int TC_W = $clog2(DONE_TIMEOUT + 1);

  localparam logic [ADDR_W-1:0] LAST_IDX =
    ADDR_W'(NUM_LEDS - 1);
  localparam logic [LC_W-1:0] LC_END =
    LC_W'(RESET_CYCLES - 1);
  localparam logic [TC_W-1:0] TC_END =
    TC_W'(DONE_TIMEOUT - 1);

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              pend_q, pend_d;
  logic [LC_W-1:0]   lcnt_q, lcnt_d;
  logic [TC_W-1:0]   tcnt_q, tcnt_d;
  logic              err_q, err_d;
  rgb_t              rgb_q, rgb_d;
  logic              rd_q, rd_d;
  logic              load_q, load_d;
  logic              busy_q, busy_d;
  logic              fdone_q, fdone_d;
  rgb_t              scaled;

  pixel_scale u_scale (
    .pix_in  (rgb_t'(pix_data)),
    .bright  (bright),
    .pix_out (scaled)
  );

  // next-state logic; outputs are derived from the next state
  // so that every output leaves the flops glitch-free
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    lcnt_d  = lcnt_q;
    tcnt_d  = tcnt_q;
    err_d   = err_q;
    rgb_d   = rgb_q;

    if (start && state_q != IDLE) pend_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          idx_d   = '0;
          err_d   = 1'b0;
          pend_d  = 1'b0;
        end
      end
      FETCH: state_d = WAIT_DATA;
      WAIT_DATA: begin
        rgb_d   = scaled;
        state_d = LOAD;
      end
      LOAD: begin
        tcnt_d  = '0;
        state_d = SEND;
      end
      SEND: begin
        if (drv_done) begin
          if (idx_q == LAST_IDX) begin
            state_d = LATCH;
            lcnt_d  = '0;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = FETCH;
          end
        end else if (tcnt_q == TC_END) begin
          err_d   = 1'b1;
          state_d = LATCH;
          lcnt_d  = '0;
        end else begin
          tcnt_d = tcnt_q + TC_W'(1);
        end
      end
      LATCH: begin
        if (lcnt_q == LC_END) begin
          if (pend_q || start) begin
            pend_d  = 1'b0;
            idx_d   = '0;
            state_d = FETCH;
          end else begin
            state_d = IDLE;
          end
        end else begin
          lcnt_d = lcnt_q + LC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    rd_d    = (state_d == FETCH);
    load_d  = (state_d == LOAD);
    busy_d  = (state_d != IDLE);
    fdone_d = (state_d == LATCH) && (lcnt_d == LC_END);
  end

  // state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pend_q  <= 1'b0;
      lcnt_q  <= '0;
      tcnt_q  <= '0;
      err_q   <= 1'b0;
      rgb_q   <= '0;
      rd_q    <= 1'b0;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      fdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      lcnt_q  <= lcnt_d;
      tcnt_q  <= tcnt_d;
      err_q   <= err_d;
      rgb_q   <= rgb_d;
      rd_q    <= rd_d;
      load_q  <= load_d;
      busy_q  <= busy_d;
      fdone_q <= fdone_d;
    end
  end

  assign pix_rd     = rd_q;
  assign pix_addr   = idx_q;
  assign drv_rgb    = rgb_q;
  assign drv_load   = load_q;
  assign busy       = busy_q;
  assign frame_done = fdone_q;
  assign err        = err_q;

endmodule
